keypad_matrix_scanner: RTL
==========================

// Module: keypad_matrix_scanner
// PURPOSE
// - Scans a 4x4 key matrix: drives one row low at a time and samples the 4 column inputs.
// - Debounces each press and reports it as a 4-bit hex code (0-F) plus a single-cycle valid strobe.
// - This is the input-side counterpart of the LED matrix scan path. key_value feeds the 4-bit
//   button/code input of the 8x8 LED matrix font display.
// PARAMETERS
// - DIV_BITS  16  scan tick period = 2**DIV_BITS clk cycles; the bench uses 2.
// - DEBOUNCE  3   number of consecutive identical tick samples needed to accept a press or a release (>=1).
// PORTS
// - clk          input   1  system clock, rising edge
// - reset_n      input   1  synchronous, active-low reset
// - key_col      input   4  matrix columns; active low; external pull-ups; asynchronous to clk
// - key_row      output  4  matrix row drive; active low; exactly one bit low at all times
// - key_value    output  4  code of the last accepted key: row_idx*4 + col_idx
// - key_valid    output  1  one-clk pulse when a press is accepted
// - key_pressed  output  1  high while the accepted key is held (until its release is debounced)
// BEHAVIOUR
// - Reset (reset_n=0 at posedge clk):
//   - key_row=4'b1110, key_value=0, key_valid=0, key_pressed=0.
//   - State=SCAN; the divider, debounce count and synchronizer all clear.
//   - Reset has priority in every state, including mid-DEBOUNCE. A press in progress is discarded
//     and no strobe is issued.
// - key_col passes through a 2-FF synchronizer to give col_s. Sampling uses col_s only.
// - Tick: a DIV_BITS-bit free-running counter. tick=1 for one clk when the counter wraps to 0.
//   The FSM acts only on tick cycles; it holds state otherwise.
// - Column priority: if several bits of col_s are low, col_idx = the lowest-index low bit.
// - row_idx = position of the 0 in key_row.
// - SCAN:
//   - On tick with col_s==4'b1111: rotate key_row left (1110->1101->1011->0111->1110).
//   - On tick with any col_s bit low: latch cand = {row_idx, col_idx}, set cnt=1, go DEBOUNCE.
//     key_row is frozen from this point.
// - DEBOUNCE (row frozen):
//   - On tick with the same lowest-low col_idx: cnt++.
//   - When cnt reaches DEBOUNCE: key_value<=cand, key_valid=1 for that single clk,
//     key_pressed<=1, go HELD.
//   - With DEBOUNCE=1, acceptance happens on the entry tick itself.
//   - On tick with a different pattern (including all high): cnt=0, rotate the row, go SCAN.
//     No output changes.
// - HELD (row frozen):
//   - On tick with col_s==1111: cnt++. Any low bit clears cnt to 0.
//   - When cnt reaches DEBOUNCE: key_pressed<=0, cnt=0, rotate the row, go SCAN.
//   - key_value holds its value until the next accepted press.
// - key_valid fires exactly once per accepted press. Holding a key never re-strobes.
//   Keys pressed in other rows during HELD are ignored.
// - Press-to-strobe latency from a stable col input, once its row is driven:
//   2 clk (synchronizer) + up to DEBOUNCE ticks.
// - key_row, key_value, key_valid and key_pressed are all registered outputs.
// TESTING (DIV_BITS=2, DEBOUNCE=3; the bench models switches: key_col[c]=0 iff switch (r,c) closed and key_row[r]==0)
// 1. Reset
//    - Stimulus: reset_n=0 for 3 clk with key_col=4'b0000.
//    - Required: key_row=1110, key_value=0, key_valid=0, key_pressed=0 throughout.
// 2. Idle scan
//    - Stimulus: key_col=1111.
//    - Required: key_row steps 1110,1101,1011,0111,1110, one step per 4 clk. key_valid stays 0.
// 3. Single press
//    - Stimulus: close (2,1).
//    - Required: key_row freezes at 1011; key_value=4'h9; exactly one 1-clk key_valid;
//      key_pressed=1 while the switch stays closed.
// 4. Bounce
//    - Stimulus: close (1,3) for 1 tick, open for 1 tick, repeat 3 times.
//    - Required: no key_valid, key_value unchanged, scanning resumes.
// 5. Release and multi-key
//    - Stimulus A: from step 3, open (2,1).
//    - Required A: key_pressed falls after 3 all-high ticks; no second strobe; rotation resumes at 0111.
//    - Stimulus B: close (0,0) and (0,3) together.
//    - Required B: key_value=4'h0.
// 6. Reset mid-debounce
//    - Stimulus: close (3,2); assert reset_n=0 after 2 ticks.
//    - Required: reset values on the next clk; no key_valid;
//      after release of reset the press is re-debounced and accepted as 4'hE.

Source files
------------

// File: rtl/keypad_matrix_scanner.sv
// 4x4 key matrix scanner: walks a single low row across the matrix, samples the
// synchronized columns on each divider tick, debounces press and release, and
// reports the accepted key as a hex code with a one-clock valid strobe.
module keypad_matrix_scanner #(
    parameter int unsigned DIV_BITS = 16,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] key_col,
    output logic [3:0] key_row,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       key_pressed
);

    localparam int unsigned    CntW   = $clog2(DEBOUNCE + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE);

    localparam logic [1:0] StScan     = 2'd0;
    localparam logic [1:0] StDebounce = 2'd1;
    localparam logic [1:0] StHeld     = 2'd2;

    logic [3:0]          col_meta_q, col_s;
    logic [DIV_BITS-1:0] div_q;
    logic [1:0]          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [3:0]          row_q, row_d, row_rot;
    logic [3:0]          cand_q, cand_d;
    logic [3:0]          value_q, value_d;
    logic                valid_q, valid_d;
    logic                pressed_q, pressed_d;
    logic                tick;
    logic                col_any_low;
    logic [1:0]          col_idx;
    logic [1:0]          row_idx;

    assign tick        = &div_q;
    assign col_any_low = ~&col_s;
    assign row_rot     = {row_q[2:0], row_q[3]};
    assign cnt_inc     = cnt_q + CntW'(1);

    // Lowest-index low column wins when several keys share the driven row.
    always_comb begin
        col_idx = 2'd0;
        if (!col_s[0])      col_idx = 2'd0;
        else if (!col_s[1]) col_idx = 2'd1;
        else if (!col_s[2]) col_idx = 2'd2;
        else if (!col_s[3]) col_idx = 2'd3;
    end

    // Decode the position of the single low bit in the row drive.
    always_comb begin
        row_idx = 2'd0;
        case (row_q)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    // Scan / debounce / held state machine; only advances on divider ticks.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        cand_d    = cand_q;
        value_d   = value_q;
        valid_d   = 1'b0;
        pressed_d = pressed_q;
        if (tick) begin
            case (state_q)
                StScan: begin
                    if (!col_any_low) begin
                        row_d = row_rot;
                    end else begin
                        cand_d = {row_idx, col_idx};
                        if (DEBOUNCE == 1) begin
                            // A single stable sample is enough: accept on entry.
                            value_d   = {row_idx, col_idx};
                            valid_d   = 1'b1;
                            pressed_d = 1'b1;
                            cnt_d     = '0;
                            state_d   = StHeld;
                        end else begin
                            cnt_d   = CntW'(1);
                            state_d = StDebounce;
                        end
                    end
                end
                StDebounce: begin
                    if (col_any_low && (col_idx == cand_q[1:0])) begin
                        if (cnt_inc == CntMax) begin
                            value_d   = cand_q;
                            valid_d   = 1'b1;
                            pressed_d = 1'b1;
                            cnt_d     = '0;
                            state_d   = StHeld;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = '0;
                        row_d   = row_rot;
                        state_d = StScan;
                    end
                end
                StHeld: begin
                    if (!col_any_low) begin
                        if (cnt_inc == CntMax) begin
                            pressed_d = 1'b0;
                            cnt_d     = '0;
                            row_d     = row_rot;
                            state_d   = StScan;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Any bounce back to low restarts the release count.
                        cnt_d = '0;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = StScan;
                end
            endcase
        end
    end

    // Register the synchronizer, divider, FSM state and all outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col_meta_q <= 4'b1111;
            col_s      <= 4'b1111;
            div_q      <= '0;
            state_q    <= StScan;
            cnt_q      <= '0;
            row_q      <= 4'b1110;
            cand_q     <= 4'h0;
            value_q    <= 4'h0;
            valid_q    <= 1'b0;
            pressed_q  <= 1'b0;
        end else begin
            col_meta_q <= key_col;
            col_s      <= col_meta_q;
            div_q      <= div_q + DIV_BITS'(1);
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            cand_q     <= cand_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            pressed_q  <= pressed_d;
        end
    end

    assign key_row     = row_q;
    assign key_value   = value_q;
    assign key_valid   = valid_q;
    assign key_pressed = pressed_q;

endmodule
